// File: rtl/rs_sfu_fetch.sv
// SFU-side read engine: fetches result-SRAM lines one at a time and streams them
// to the SFU as BEAT_W-bit beats, zeroing bytes past the end of the region.
module rs_sfu_fetch #(
    parameter int LINE_W = 32768,
    parameter int BEAT_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] total_bytes,
    output logic              busy,
    output logic              done,
    output logic              rs_rd_en,
    output logic [ADDR_W-1:0] rs_rd_addr,
    input  logic [LINE_W-1:0] rs_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last
);
    localparam int LINE_B = LINE_W / 8;
    localparam int BEAT_B = BEAT_W / 8;
    localparam int NBEAT  = LINE_W / BEAT_W;
    localparam int BI_W   = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAPT, S_STREAM, S_DONE} state_t;

    state_t            r_state;
    logic [LINE_W-1:0] r_buf;
    logic [ADDR_W-1:0] r_bytes_left;
    logic [BI_W-1:0]   r_beat_idx;

    logic              w_hs;
    logic              w_wrap;
    logic [BI_W-1:0]   w_beat_nxt;
    logic [ADDR_W-1:0] w_left_nxt;
    logic [BEAT_W-1:0] w_next_beat;

    // Zero every byte at or beyond the remaining byte count (partial final beat).
    function automatic logic [BEAT_W-1:0] mask_beat(input logic [BEAT_W-1:0] d,
                                                    input logic [ADDR_W-1:0] left);
        mask_beat = d;
        for (int k = 0; k < BEAT_B; k++)
            if (ADDR_W'(k) >= left) mask_beat[8*k +: 8] = '0;
    endfunction

    assign w_hs        = out_valid && out_ready;
    assign w_wrap      = (r_beat_idx == BI_W'(NBEAT - 1));
    assign w_beat_nxt  = r_beat_idx + 1'b1;
    assign w_left_nxt  = (r_bytes_left > ADDR_W'(BEAT_B)) ? r_bytes_left - ADDR_W'(BEAT_B) : '0;
    assign w_next_beat = r_buf[BEAT_W*int'(w_beat_nxt) +: BEAT_W];

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            r_state      <= S_IDLE;
            r_buf        <= '0;
            r_bytes_left <= '0;
            r_beat_idx   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rs_rd_en     <= 1'b0;
            rs_rd_addr   <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bytes_left <= total_bytes;
                        rs_rd_addr   <= base_addr;
                        if (total_bytes == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= S_REQ;
                            busy     <= 1'b1;
                            rs_rd_en <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    rs_rd_en <= 1'b0;
                    r_state  <= S_CAPT;
                end
                S_CAPT: begin
                    // Read data arrives this cycle; first beat comes straight from it.
                    r_buf      <= rs_rd_data;
                    r_beat_idx <= '0;
                    out_valid  <= 1'b1;
                    out_data   <= mask_beat(rs_rd_data[BEAT_W-1:0], r_bytes_left);
                    out_last   <= (r_bytes_left <= ADDR_W'(BEAT_B));
                    r_state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        r_bytes_left <= w_left_nxt;
                        r_beat_idx   <= w_beat_nxt;
                        if (w_left_nxt == '0) begin
                            r_state   <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else if (w_wrap) begin
                            r_state    <= S_REQ;
                            r_beat_idx <= '0;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            rs_rd_en   <= 1'b1;
                            rs_rd_addr <= rs_rd_addr + ADDR_W'(LINE_B);
                        end else begin
                            out_data <= mask_beat(w_next_beat, w_left_nxt);
                            out_last <= (w_left_nxt <= ADDR_W'(BEAT_B));
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_sfu_fetch.sv
// Randomized bench: SRAM content is a hash of the byte address; expected reads and
// beats are derived from the byte region directly and compared at negedge.
module tb_rs_sfu_fetch;
    localparam int LINE_W = 32768;
    localparam int BEAT_W = 256;
    localparam int ADDR_W = 32;
    localparam int LINE_B = LINE_W / 8;
    localparam int BEAT_B = BEAT_W / 8;
    localparam int NBEAT  = LINE_W / BEAT_W;

    logic              clk = 1'b0;
    logic              RSTn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] total_bytes = '0;
    logic              busy, done, rs_rd_en, out_valid, out_last;
    logic [ADDR_W-1:0] rs_rd_addr;
    logic [LINE_W-1:0] rd_data = '0;
    logic              out_ready = 1'b0;
    logic [BEAT_W-1:0] out_data;

    rs_sfu_fetch #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .RSTn(RSTn), .start(start), .base_addr(base_addr),
        .total_bytes(total_bytes), .busy(busy), .done(done), .rs_rd_en(rs_rd_en),
        .rs_rd_addr(rs_rd_addr), .rs_rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        mem_byte = a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ a[31:24] ^ 8'hA5;
    endfunction

    // SRAM read port: line valid the cycle after the strobe, scrambled otherwise.
    always @(posedge clk) begin
        if (rs_rd_en) begin
            for (int k = 0; k < LINE_B; k++) rd_data[8*k +: 8] <= mem_byte(rs_rd_addr + 32'(k));
        end else begin
            rd_data <= ~rd_data;
        end
    end

    logic [31:0]       exp_rd[$];
    logic [BEAT_W-1:0] exp_beats[$];
    int  rd_cnt, beat_cnt, done_cnt, last_acc;
    bit  mon_en = 1'b0;
    bit  rnd_rdy = 1'b0;
    bit  prev_stall = 1'b0;
    logic [BEAT_W-1:0] prev_data;
    logic              prev_last;

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (rs_rd_en) begin
                if (rd_cnt < exp_rd.size()) chk("rd_addr", rs_rd_addr, exp_rd[rd_cnt]);
                else chk("extra_read", 1, 0);
                rd_cnt++;
            end
            if (out_valid && prev_stall) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (beat_cnt < exp_beats.size()) begin
                    chk("beat_data", out_data, exp_beats[beat_cnt]);
                    chk("beat_last", out_last, beat_cnt == exp_beats.size() - 1);
                end else chk("extra_beat", 1, 0);
                if (!rnd_rdy && beat_cnt > 0)
                    chk("beat_gap", cyc - last_acc, (beat_cnt % NBEAT == 0) ? 3 : 1);
                last_acc = cyc;
                beat_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (exp_beats.size() > 0) chk("done_lat", cyc - last_acc, 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic run_job(input logic [31:0] base, input logic [31:0] len, input bit rnd, input bit poke);
        logic [BEAT_W-1:0] b;
        int  n;
        bit  got;
        exp_rd.delete();
        exp_beats.delete();
        for (int j = 0; j * LINE_B < len; j++) exp_rd.push_back(base + 32'(j * LINE_B));
        for (int i = 0; i * BEAT_B < len; i++) begin
            b = '0;
            for (int k = 0; k < BEAT_B; k++)
                if (i * BEAT_B + k < len) b[8*k +: 8] = mem_byte(base + 32'(i * BEAT_B + k));
            exp_beats.push_back(b);
        end
        rd_cnt = 0; beat_cnt = 0; done_cnt = 0; last_acc = 0;
        rnd_rdy = rnd; prev_stall = 1'b0; mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; total_bytes = len;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0; base_addr = $urandom; total_bytes = 32'($urandom_range(1, 100));
        got = done;
        if (len == 0) begin
            chk("zero_done", done, 1);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("start_in_done", busy, 0);
        end
        n = 0;
        while (!got && n < 20000) begin
            start = (poke && n == 3);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            got = done; n++;
        end
        start = 1'b0;
        if (!got) chk("timeout", 0, 1);
        @(negedge clk); #1;
        chk("read_count", rd_cnt, exp_rd.size());
        chk("beat_count", beat_cnt, exp_beats.size());
        chk("done_count", done_cnt, 1);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        mon_en = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rden"}, rs_rd_en, 0);
        chk({tag, "_raddr"}, rs_rd_addr, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        RSTn = 1'b1;
        run_job(32'h100, 64, 0, 0);
        run_job(32'h1_0000, LINE_B + 32, 0, 1);
        run_job(32'h2000, 40, 0, 0);
        run_job($urandom, 256, 1, 0);
        run_job(32'h55, 0, 0, 0);
        run_job(32'hFFFF_F800, 4200, 1, 1);
        for (int r = 0; r < 4; r++) run_job($urandom, 32'($urandom_range(1, 9000)), 1, 0);

        // Reset in the middle of streaming abandons the job without a done pulse.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h4000; total_bytes = 4096; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("pre_rst_valid", out_valid, 1);
        RSTn = 1'b0;
        @(posedge clk); #1;
        chk_zero("midrst");
        RSTn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done", done, 0);
        end
        run_job(32'h100, 64, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
